// File: rtl/ob_mem_drain_if.sv
// Output-buffer drain bus: the memory control/read port plus the row stream.
// The master side is the drain engine; the slave side is the memory and the consumer.
interface ob_mem_drain_if #(
   parameter int WIDTH  = 8,
   parameter int COL    = 4,
   parameter int O_SIZE = 256
);
   localparam int ADDR_W = $clog2(O_SIZE);
   localparam int DATA_W = COL * WIDTH;

   logic              mem_cenb_o;
   logic              mem_wenb_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_q_i;
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              ready_i;

   modport master (
      output mem_cenb_o, mem_wenb_o, mem_addr_o, data_o, valid_o,
      input  mem_q_i, ready_i
   );

   modport slave (
      input  mem_cenb_o, mem_wenb_o, mem_addr_o, data_o, valid_o,
      output mem_q_i, ready_i
   );
endinterface

// File: rtl/ob_mem_drain.sv
// Output-buffer drain engine: sweeps a row window of the output buffer through
// its external read port and streams each row out on a valid/ready interface.
// Returned rows land in a registered head stage backed by a 2-entry skid FIFO,
// which together cover the two reads that can still be in the memory pipeline
// when the consumer stalls.
module ob_mem_drain #(
   parameter  int WIDTH  = 8,
   parameter  int COL    = 4,
   parameter  int O_SIZE = 256,
   localparam int ADDR_W = $clog2(O_SIZE),
   localparam int DATA_W = COL * WIDTH
) (
   input  logic              clk_i,
   input  logic              rstn_async_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W:0]   count_i,
   ob_mem_drain_if.master    bus,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_W:0] ONE_ROW = (ADDR_W+1)'(1);

   state_t            state_q;
   logic              cenb_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] next_addr_q;
   logic [ADDR_W:0]   remain_q;
   logic              pend_q;
   logic              busy_q;
   logic              done_q;

   logic [DATA_W-1:0] head_data_q;
   logic              head_valid_q;
   logic [DATA_W-1:0] skid_mem [2];
   logic              skid_rd_q;
   logic              skid_wr_q;
   logic [1:0]        skid_cnt_q;

   logic              pop;
   logic              push;
   logic              head_free;
   logic              skid_take;
   logic              skid_put;
   logic [2:0]        occupancy;
   logic [2:0]        inflight;
   logic              can_issue;
   logic              drain_empty;

   // pend_q marks the cycle in which mem_q_i carries the row read one cycle earlier
   assign pop         = head_valid_q & bus.ready_i;
   assign push        = pend_q;
   assign head_free   = ~head_valid_q | pop;
   assign skid_take   = head_free & (skid_cnt_q != 2'd0);
   assign skid_put    = push & ~(head_free & (skid_cnt_q == 2'd0));
   assign occupancy   = {2'b00, head_valid_q} + {1'b0, skid_cnt_q};
   assign inflight    = {2'b00, ~cenb_q} + {2'b00, pend_q};
   // a new read must still fit even if the consumer stalls from now on
   assign can_issue   = (occupancy + inflight) < (3'd3 + {2'b00, pop});
   assign drain_empty = cenb_q & ~pend_q & (skid_cnt_q == 2'd0) & (~head_valid_q | pop);

   // Sweep control: captures the window, issues reads and sequences done
   always_ff @(posedge clk_i or negedge rstn_async_i) begin
      if (!rstn_async_i) begin
         state_q     <= S_IDLE;
         cenb_q      <= 1'b1;
         addr_q      <= '0;
         next_addr_q <= '0;
         remain_q    <= '0;
         pend_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cenb_q <= 1'b1;
         done_q <= 1'b0;
         pend_q <= ~cenb_q;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (count_i == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     // the first read goes out on the start edge itself
                     cenb_q      <= 1'b0;
                     addr_q      <= base_addr_i;
                     next_addr_q <= base_addr_i + 1'b1;
                     remain_q    <= count_i - ONE_ROW;
                     busy_q      <= 1'b1;
                     state_q     <= (count_i == ONE_ROW) ? S_DRAIN : S_READ;
                  end
               end
            end
            S_READ: begin
               if (can_issue) begin
                  cenb_q      <= 1'b0;
                  addr_q      <= next_addr_q;
                  next_addr_q <= next_addr_q + 1'b1;
                  remain_q    <= remain_q - ONE_ROW;
                  if (remain_q == ONE_ROW) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_empty) begin
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Head stage and skid pointers: head refills from the skid first, then from memory
   always_ff @(posedge clk_i or negedge rstn_async_i) begin
      if (!rstn_async_i) begin
         head_data_q  <= '0;
         head_valid_q <= 1'b0;
         skid_rd_q    <= 1'b0;
         skid_wr_q    <= 1'b0;
         skid_cnt_q   <= 2'd0;
      end else begin
         if (head_free) begin
            if (skid_cnt_q != 2'd0) begin
               head_data_q  <= skid_mem[skid_rd_q];
               head_valid_q <= 1'b1;
            end else if (push) begin
               head_data_q  <= bus.mem_q_i;
               head_valid_q <= 1'b1;
            end else begin
               head_valid_q <= 1'b0;
            end
         end
         if (skid_take) begin
            skid_rd_q <= ~skid_rd_q;
         end
         if (skid_put) begin
            skid_wr_q <= ~skid_wr_q;
         end
         skid_cnt_q <= skid_cnt_q + {1'b0, skid_put} - {1'b0, skid_take};
      end
   end

   // Skid storage: plain data slots, validity lives in the pointers above
   always_ff @(posedge clk_i) begin
      if (skid_put) begin
         skid_mem[skid_wr_q] <= bus.mem_q_i;
      end
   end

   assign bus.mem_cenb_o = cenb_q;
   assign bus.mem_wenb_o = 1'b1;
   assign bus.mem_addr_o = addr_q;
   assign bus.data_o     = head_data_q;
   assign bus.valid_o    = head_valid_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;

endmodule

// File: tb/tb_ob_mem_drain.sv
// Bench for ob_mem_drain: synchronous-read memory model, scenario tasks that
// record what the drain does, and inline comparisons against a window model.
module tb_ob_mem_drain;
   localparam int WIDTH  = 8;
   localparam int COL    = 4;
   localparam int O_SIZE = 256;
   localparam int ADDR_W = 8;
   localparam int DW     = COL * WIDTH;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   count = '0;
   logic              busy;
   logic              done;

   int vec_cnt = 0;
   int err_cnt = 0;

   ob_mem_drain_if #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) bus ();

   ob_mem_drain #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
      .clk_i       (clk),
      .rstn_async_i(rst_n),
      .start_i     (start),
      .base_addr_i (base_addr),
      .count_i     (count),
      .bus         (bus),
      .busy_o      (busy),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   // memory: data only valid the cycle after a cenb-low edge, garbage otherwise
   logic [DW-1:0] mem_arr [O_SIZE];
   always @(posedge clk) begin
      if (!bus.mem_cenb_o) bus.mem_q_i <= mem_arr[bus.mem_addr_o];
      else                 bus.mem_q_i <= $urandom;
   end

   // observations of one sweep (k = cycles after the start-sampling edge)
   int            obs_addr [$];
   int            obs_ck   [$];
   int            obs_hk   [$];
   logic [DW-1:0] obs_data [$];
   int            done_k, done_cnt, stall_viol, first_valid_k, busy_hi_cnt;
   logic          busy_k0, busy_at_done;

   function automatic logic [DW-1:0] exp_row(int b, int i);
      return mem_arr[(b + i) % O_SIZE];
   endfunction

   // rmode: 0 ready=1, 1 pattern 1,0,0,1, 2 random; restart_k re-pulses start; abort_hs stops early
   task automatic do_sweep(input int b, input int cnt, input int rmode,
                           input int restart_k, input int abort_hs);
      int k;
      int budget;
      logic r;
      logic prev_stall;
      logic [DW-1:0] prev_data;
      obs_addr.delete(); obs_ck.delete(); obs_hk.delete(); obs_data.delete();
      done_k = -1; done_cnt = 0; stall_viol = 0; first_valid_k = -1;
      busy_hi_cnt = 0; busy_k0 = 1'b0; busy_at_done = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = ADDR_W'(b);
      count = (ADDR_W+1)'(cnt);
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = ADDR_W'($urandom);
      count = (ADDR_W+1)'($urandom);
      k = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      budget = cnt * 6 + 20;
      while (k < budget) begin
         if (!bus.mem_cenb_o) begin
            obs_addr.push_back(int'(bus.mem_addr_o));
            obs_ck.push_back(k);
         end
         if (busy) busy_hi_cnt++;
         if (k == 0) busy_k0 = busy;
         if (done) begin
            done_cnt++;
            if (done_k < 0) begin
               done_k = k;
               busy_at_done = busy;
            end
         end
         if (prev_stall && (!bus.valid_o || bus.data_o !== prev_data)) stall_viol++;
         if (bus.valid_o && first_valid_k < 0) first_valid_k = k;
         start = (k == restart_k);
         case (rmode)
            0:       r = 1'b1;
            1:       r = ((k % 4) == 0) || ((k % 4) == 3);
            default: r = 1'($urandom);
         endcase
         bus.ready_i = r;
         if (bus.valid_o && r) begin
            obs_data.push_back(bus.data_o);
            obs_hk.push_back(k + 1);
         end
         prev_stall = bus.valid_o && !r;
         prev_data = bus.data_o;
         if (done_k >= 0 && k >= done_k + 3) break;
         @(posedge clk); #1;
         k++;
         if (abort_hs >= 0 && obs_data.size() >= abort_hs) break;
      end
      start = 1'b0;
      bus.ready_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++; if (bus.mem_cenb_o !== 1'b1) begin err_cnt++; $display("FAIL reset_cenb: got %b expected 1", bus.mem_cenb_o); end
      vec_cnt++; if (bus.mem_wenb_o !== 1'b1) begin err_cnt++; $display("FAIL reset_wenb: got %b expected 1", bus.mem_wenb_o); end
      vec_cnt++; if (bus.mem_addr_o !== '0) begin err_cnt++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr_o); end
      vec_cnt++; if (bus.data_o !== '0) begin err_cnt++; $display("FAIL reset_data: got %h expected 0", bus.data_o); end
      vec_cnt++; if (bus.valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b expected 0", done); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      vec_cnt++; if (bus.mem_cenb_o !== 1'b1 || bus.valid_o !== 1'b0) begin err_cnt++; $display("FAIL idle_after_reset: cenb %b valid %b expected 1 0", bus.mem_cenb_o, bus.valid_o); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4; i++) mem_arr[i] = 32'hA0A0A0A0 + 32'(i);
      do_sweep(0, 4, 0, -1, -1);
      vec_cnt++; if (obs_addr.size() !== 4) begin err_cnt++; $display("FAIL basic_nreads: got %0d expected 4", obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
         vec_cnt++; if (obs_addr[i] !== i || obs_ck[i] !== i) begin err_cnt++; $display("FAIL basic_read[%0d]: addr %0d at k=%0d expected addr %0d at k=%0d", i, obs_addr[i], obs_ck[i], i, i); end
      end
      vec_cnt++; if (obs_data.size() !== 4) begin err_cnt++; $display("FAIL basic_nrows: got %0d expected 4", obs_data.size()); end
      for (int i = 0; i < obs_data.size() && i < 4; i++) begin
         vec_cnt++; if (obs_data[i] !== 32'hA0A0A0A0 + 32'(i) || obs_hk[i] !== i + 3) begin err_cnt++; $display("FAIL basic_row[%0d]: %h at edge %0d expected %h at edge %0d", i, obs_data[i], obs_hk[i], 32'hA0A0A0A0 + 32'(i), i + 3); end
      end
      vec_cnt++; if (first_valid_k !== 2) begin err_cnt++; $display("FAIL basic_first_valid: got k=%0d expected 2", first_valid_k); end
      vec_cnt++; if (done_k !== 7 || done_cnt !== 1) begin err_cnt++; $display("FAIL basic_done: k=%0d pulses=%0d expected k=7 pulses=1", done_k, done_cnt); end
      vec_cnt++; if (busy_k0 !== 1'b1 || busy_at_done !== 1'b0) begin err_cnt++; $display("FAIL basic_busy: start %b done %b expected 1 0", busy_k0, busy_at_done); end
   endtask

   task automatic test_wrap();
      do_sweep(254, 4, 0, -1, -1);
      vec_cnt++; if (obs_addr.size() !== 4 || obs_data.size() !== 4) begin err_cnt++; $display("FAIL wrap_counts: reads %0d rows %0d expected 4 4", obs_addr.size(), obs_data.size()); end
      for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
         vec_cnt++; if (obs_addr[i] !== (254 + i) % O_SIZE) begin err_cnt++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, obs_addr[i], (254 + i) % O_SIZE); end
      end
      for (int i = 0; i < obs_data.size() && i < 4; i++) begin
         vec_cnt++; if (obs_data[i] !== exp_row(254, i)) begin err_cnt++; $display("FAIL wrap_row[%0d]: got %h expected %h", i, obs_data[i], exp_row(254, i)); end
      end
      vec_cnt++; if (done_k !== 7) begin err_cnt++; $display("FAIL wrap_done: got k=%0d expected 7", done_k); end
   endtask

   task automatic test_backpressure();
      int b;
      b = $urandom_range(0, O_SIZE - 1);
      do_sweep(b, 8, 1, -1, -1);
      vec_cnt++; if (obs_data.size() !== 8 || obs_addr.size() !== 8) begin err_cnt++; $display("FAIL bp_counts: rows %0d reads %0d expected 8 8", obs_data.size(), obs_addr.size()); end
      for (int i = 0; i < obs_data.size() && i < 8; i++) begin
         vec_cnt++; if (obs_data[i] !== exp_row(b, i)) begin err_cnt++; $display("FAIL bp_row[%0d]: got %h expected %h", i, obs_data[i], exp_row(b, i)); end
      end
      vec_cnt++; if (stall_viol !== 0) begin err_cnt++; $display("FAIL bp_stall_stable: %0d unstable stall cycles expected 0", stall_viol); end
      if (obs_hk.size() > 0) begin
         vec_cnt++; if (done_k !== obs_hk[obs_hk.size() - 1] + 1 || done_cnt !== 1) begin err_cnt++; $display("FAIL bp_done: k=%0d pulses=%0d expected k=%0d pulses=1", done_k, done_cnt, obs_hk[obs_hk.size() - 1] + 1); end
      end
   endtask

   task automatic test_count_zero();
      do_sweep($urandom_range(0, O_SIZE - 1), 0, 0, -1, -1);
      vec_cnt++; if (obs_addr.size() !== 0) begin err_cnt++; $display("FAIL zero_reads: got %0d expected 0", obs_addr.size()); end
      vec_cnt++; if (obs_data.size() !== 0) begin err_cnt++; $display("FAIL zero_rows: got %0d expected 0", obs_data.size()); end
      vec_cnt++; if (done_k !== 1 || done_cnt !== 1) begin err_cnt++; $display("FAIL zero_done: k=%0d pulses=%0d expected k=1 pulses=1", done_k, done_cnt); end
      vec_cnt++; if (busy_hi_cnt !== 0) begin err_cnt++; $display("FAIL zero_busy: %0d busy cycles expected 0", busy_hi_cnt); end
   endtask

   task automatic test_restart_ignored();
      int b;
      b = $urandom_range(0, O_SIZE - 1);
      do_sweep(b, 16, 2, 5, -1);
      vec_cnt++; if (obs_data.size() !== 16 || obs_addr.size() !== 16) begin err_cnt++; $display("FAIL restart_counts: rows %0d reads %0d expected 16 16", obs_data.size(), obs_addr.size()); end
      for (int i = 0; i < obs_data.size() && i < 16; i++) begin
         vec_cnt++; if (obs_data[i] !== exp_row(b, i)) begin err_cnt++; $display("FAIL restart_row[%0d]: got %h expected %h", i, obs_data[i], exp_row(b, i)); end
      end
      for (int i = 0; i < obs_addr.size() && i < 16; i++) begin
         vec_cnt++; if (obs_addr[i] !== (b + i) % O_SIZE) begin err_cnt++; $display("FAIL restart_addr[%0d]: got %0d expected %0d", i, obs_addr[i], (b + i) % O_SIZE); end
      end
      vec_cnt++; if (done_cnt !== 1 || stall_viol !== 0) begin err_cnt++; $display("FAIL restart_done: pulses=%0d stalls=%0d expected 1 0", done_cnt, stall_viol); end
   endtask

   task automatic test_reset_mid();
      do_sweep($urandom_range(0, O_SIZE - 1), 8, 0, -1, 3);
      rst_n = 1'b0;
      #2;
      vec_cnt++; if (obs_data.size() !== 3) begin err_cnt++; $display("FAIL mid_hs_before_abort: got %0d expected 3", obs_data.size()); end
      vec_cnt++; if (bus.valid_o !== 1'b0 || bus.data_o !== '0) begin err_cnt++; $display("FAIL mid_reset_stream: valid %b data %h expected 0 0", bus.valid_o, bus.data_o); end
      vec_cnt++; if (bus.mem_cenb_o !== 1'b1 || bus.mem_addr_o !== '0) begin err_cnt++; $display("FAIL mid_reset_mem: cenb %b addr %0d expected 1 0", bus.mem_cenb_o, bus.mem_addr_o); end
      vec_cnt++; if (busy !== 1'b0 || done !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_status: busy %b done %b expected 0 0", busy, done); end
      @(negedge clk);
      rst_n = 1'b1;
      do_sweep(10, 2, 0, -1, -1);
      vec_cnt++; if (obs_data.size() !== 2) begin err_cnt++; $display("FAIL mid_restart_rows: got %0d expected 2", obs_data.size()); end
      for (int i = 0; i < obs_data.size() && i < 2; i++) begin
         vec_cnt++; if (obs_data[i] !== mem_arr[10 + i]) begin err_cnt++; $display("FAIL mid_restart_row[%0d]: got %h expected %h", i, obs_data[i], mem_arr[10 + i]); end
      end
      vec_cnt++; if (done_k !== 5 || done_cnt !== 1) begin err_cnt++; $display("FAIL mid_restart_done: k=%0d pulses=%0d expected k=5 pulses=1", done_k, done_cnt); end
   endtask

   task automatic test_full_window();
      int b;
      int bad;
      b = $urandom_range(0, O_SIZE - 1);
      do_sweep(b, O_SIZE, 0, -1, -1);
      vec_cnt++; if (obs_data.size() !== O_SIZE || obs_addr.size() !== O_SIZE) begin err_cnt++; $display("FAIL full_counts: rows %0d reads %0d expected %0d", obs_data.size(), obs_addr.size(), O_SIZE); end
      for (int i = 0; i < obs_data.size() && i < O_SIZE; i++) begin
         vec_cnt++; if (obs_data[i] !== exp_row(b, i) || obs_hk[i] !== i + 3) begin err_cnt++; $display("FAIL full_row[%0d]: %h at edge %0d expected %h at edge %0d", i, obs_data[i], obs_hk[i], exp_row(b, i), i + 3); end
      end
      bad = 0;
      for (int i = 0; i < obs_addr.size() && i < O_SIZE; i++) begin
         if (obs_addr[i] !== (b + i) % O_SIZE || obs_ck[i] !== i) bad++;
      end
      vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL full_addr_sweep: %0d out-of-order reads expected 0", bad); end
      vec_cnt++; if (done_k !== O_SIZE + 3 || done_cnt !== 1) begin err_cnt++; $display("FAIL full_done: k=%0d pulses=%0d expected k=%0d pulses=1", done_k, done_cnt, O_SIZE + 3); end
   endtask

   task automatic test_random();
      int b;
      int n;
      for (int t = 0; t < 5; t++) begin
         b = $urandom_range(0, O_SIZE - 1);
         n = $urandom_range(1, 20);
         do_sweep(b, n, 2, -1, -1);
         vec_cnt++; if (obs_data.size() !== n) begin err_cnt++; $display("FAIL rand%0d_rows: got %0d expected %0d", t, obs_data.size(), n); end
         for (int i = 0; i < obs_data.size() && i < n; i++) begin
            vec_cnt++; if (obs_data[i] !== exp_row(b, i)) begin err_cnt++; $display("FAIL rand%0d_row[%0d]: got %h expected %h", t, i, obs_data[i], exp_row(b, i)); end
         end
         vec_cnt++; if (stall_viol !== 0) begin err_cnt++; $display("FAIL rand%0d_stall_stable: %0d unstable cycles expected 0", t, stall_viol); end
         if (obs_hk.size() > 0) begin
            vec_cnt++; if (done_k !== obs_hk[obs_hk.size() - 1] + 1 || done_cnt !== 1) begin err_cnt++; $display("FAIL rand%0d_done: k=%0d pulses=%0d expected k=%0d pulses=1", t, done_k, done_cnt, obs_hk[obs_hk.size() - 1] + 1); end
         end
      end
   endtask

   initial begin
      bus.ready_i = 1'b1;
      for (int i = 0; i < O_SIZE; i++) mem_arr[i] = $urandom;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_count_zero();
      test_restart_ignored();
      test_reset_mid();
      test_full_window();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
